// File: rtl/rv32_mem_pkg.sv
// Shared types and helpers for the RV32I memory responder.
package rv32_mem_pkg;

  // Load access types (funct3).
  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

  // Store access types (funct3).
  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_f3_e;

  // Responder life cycle: clear the array, then serve the core.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Byte enables for a store, packed as {fault, be[3:0]}.
  // A misaligned SH/SW or an unknown code yields no enables and a fault.
  function automatic logic [4:0] store_enables(input logic [2:0] f3, input logic [1:0] off);
    logic [4:0] r;
    r = 5'b0_0000;
    case (f3)
      F3_SB: r = {1'b0, 4'b0001 << off};
      F3_SH: begin
        if (off[0]) r = 5'b1_0000;
        else if (off[1]) r = 5'b0_1100;
        else r = 5'b0_0011;
      end
      F3_SW: begin
        if (off != 2'b00) r = 5'b1_0000;
        else r = 5'b0_1111;
      end
      default: r = 5'b1_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rv32_mem_responder_load_align.sv
// Extracts and sign/zero-extends a load result from a registered word.
module load_align
  import rv32_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] result
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign lane_byte = word[{offset, 3'b000} +: 8];
  assign lane_half = offset[1] ? word[31:16] : word[15:0];

  // Select and extend the addressed lane; misaligned or reserved codes give zero.
  always_comb begin
    result = 32'h0000_0000;
    case (funct3)
      F3_LB:  result = {{24{lane_byte[7]}}, lane_byte};
      F3_LBU: result = {24'h00_0000, lane_byte};
      F3_LH: begin
        if (offset[0]) result = 32'h0000_0000;
        else result = {{16{lane_half[15]}}, lane_half};
      end
      F3_LHU: begin
        if (offset[0]) result = 32'h0000_0000;
        else result = {16'h0000, lane_half};
      end
      F3_LW: begin
        if (offset != 2'b00) result = 32'h0000_0000;
        else result = word;
      end
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/rv32_mem_responder.sv
// Shared instruction/data RAM for the RV32I core with a preload port.
// The array is cleared word by word after reset before service starts.
module rv32_mem_responder
  import rv32_mem_pkg::*;
#(
  parameter int size        = 32,
  parameter int DEPTH_WORDS = 4096,
  localparam int IDX        = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [size-1:0] ins_address,
  output logic [size-1:0] instruction_i,
  output logic            instruction_valid,
  input  logic            data_mem_rw,
  input  logic [size-1:0] data_mem_addr_o,
  input  logic [size-1:0] data_mem_data_wr_data,
  input  logic [2:0]      data_mem_control,
  output logic [size-1:0] data_mem_data_rd_data,
  input  logic            load_we,
  input  logic [IDX-1:0]  load_addr,
  input  logic [size-1:0] load_data,
  output logic            init_done,
  output logic            store_fault
);

  localparam logic [IDX-1:0] LAST_IDX = IDX'(DEPTH_WORDS - 1);

  logic [size-1:0] mem [DEPTH_WORDS];

  state_e          state, next_state;
  logic [IDX-1:0]  clr_cnt_r;
  logic [IDX-1:0]  ins_idx_s, data_idx_s;
  logic [1:0]      data_off_s;
  logic            clr_we_s, ld_we_s, st_fault_s;
  logic [3:0]      st_be_s;
  logic [4:0]      st_enc_s;
  logic [size-1:0] st_wdata_s;
  logic            rd_en_r;
  logic [size-1:0] rd_word_r;
  logic [2:0]      rd_f3_r;
  logic [1:0]      rd_off_r;
  logic [size-1:0] rd_ext_s;
  logic            unused_addr_bits;

  // High address bits alias and fetch byte offsets are don't-care.
  assign ins_idx_s        = ins_address[IDX+1:2];
  assign data_idx_s       = data_mem_addr_o[IDX+1:2];
  assign data_off_s       = data_mem_addr_o[1:0];
  assign unused_addr_bits = ^{ins_address[size-1:IDX+2], ins_address[1:0],
                              data_mem_addr_o[size-1:IDX+2]};

  // State register, clear counter and init_done flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_INIT;
      clr_cnt_r <= '0;
      init_done <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ST_INIT) begin
        clr_cnt_r <= clr_cnt_r + IDX'(1);
        init_done <= (clr_cnt_r == LAST_IDX);
      end
    end
  end

  // Next state: leave INIT once the last word has been cleared.
  always_comb begin
    next_state = state;
    case (state)
      ST_INIT: begin
        if (clr_cnt_r == LAST_IDX) next_state = ST_RUN;
        else next_state = ST_INIT;
      end
      ST_RUN:  next_state = ST_RUN;
      default: next_state = ST_INIT;
    endcase
  end

  // Write controls: clear in INIT, loader and byte-enabled stores in RUN.
  always_comb begin
    clr_we_s   = 1'b0;
    ld_we_s    = 1'b0;
    st_be_s    = 4'b0000;
    st_fault_s = 1'b0;
    st_enc_s   = store_enables(data_mem_control, data_off_s);
    case (data_mem_control)
      F3_SB:   st_wdata_s = {4{data_mem_data_wr_data[7:0]}};
      F3_SH:   st_wdata_s = {2{data_mem_data_wr_data[15:0]}};
      default: st_wdata_s = data_mem_data_wr_data;
    endcase
    case (state)
      ST_INIT: clr_we_s = 1'b1;
      ST_RUN: begin
        ld_we_s = load_we;
        if (data_mem_rw) begin
          st_be_s    = st_enc_s[3:0];
          st_fault_s = st_enc_s[4];
        end else begin
          st_be_s    = 4'b0000;
          st_fault_s = 1'b0;
        end
      end
      default: clr_we_s = 1'b0;
    endcase
  end

  // Array write port; store lanes are written last so they override the loader.
  always_ff @(posedge clk) begin
    if (clr_we_s) begin
      mem[clr_cnt_r] <= '0;
    end else begin
      if (ld_we_s) mem[load_addr] <= load_data;
      for (int b = 0; b < 4; b++) begin
        if (st_be_s[b]) mem[data_idx_s][8*b +: 8] <= st_wdata_s[8*b +: 8];
      end
    end
  end

  // Sticky illegal-store flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) store_fault <= 1'b0;
    else if (st_fault_s) store_fault <= 1'b1;
  end

  // Registered fetch and data-read capture; both see pre-write array contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instruction_i     <= NOP_INSTR;
      instruction_valid <= 1'b0;
      rd_en_r           <= 1'b0;
      rd_word_r         <= '0;
      rd_f3_r           <= 3'b000;
      rd_off_r          <= 2'b00;
    end else if (state == ST_RUN) begin
      instruction_i     <= mem[ins_idx_s];
      instruction_valid <= 1'b1;
      rd_en_r           <= ~data_mem_rw;
      rd_word_r         <= mem[data_idx_s];
      rd_f3_r           <= data_mem_control;
      rd_off_r          <= data_off_s;
    end else begin
      instruction_i     <= NOP_INSTR;
      instruction_valid <= 1'b0;
      rd_en_r           <= 1'b0;
      rd_word_r         <= '0;
      rd_f3_r           <= 3'b000;
      rd_off_r          <= 2'b00;
    end
  end

  load_align u_load_align (
    .word   (rd_word_r),
    .funct3 (rd_f3_r),
    .offset (rd_off_r),
    .result (rd_ext_s)
  );

  // Read data is zero after a store, in INIT and after reset.
  assign data_mem_data_rd_data = rd_en_r ? rd_ext_s : '0;

endmodule

// File: tb/tb_rv32_mem_responder.sv
// Scoreboard bench for rv32_mem_responder.
module tb_rv32_mem_responder;

  localparam int IDX = 12;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [31:0]    ins_address = 32'h0;
  logic [31:0]    instruction_i;
  logic           instruction_valid;
  logic           data_mem_rw = 1'b0;
  logic [31:0]    data_mem_addr_o = 32'h0;
  logic [31:0]    data_mem_data_wr_data = 32'h0;
  logic [2:0]     data_mem_control = 3'b010;
  logic [31:0]    data_mem_data_rd_data;
  logic           load_we = 1'b0;
  logic [IDX-1:0] load_addr = '0;
  logic [31:0]    load_data = 32'h0;
  logic           init_done;
  logic           store_fault;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] sb_q[$];
  logic [31:0] mdl [4096];
  logic        mdl_fault;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wd;
    logic        lwe;
    logic [11:0] la;
    logic [31:0] ld;
    logic [31:0] want;
  } vec_t;

  rv32_mem_responder dut (
    .clk(clk), .reset(reset), .ins_address(ins_address),
    .instruction_i(instruction_i), .instruction_valid(instruction_valid),
    .data_mem_rw(data_mem_rw), .data_mem_addr_o(data_mem_addr_o),
    .data_mem_data_wr_data(data_mem_data_wr_data), .data_mem_control(data_mem_control),
    .data_mem_data_rd_data(data_mem_data_rd_data), .load_we(load_we),
    .load_addr(load_addr), .load_data(load_data), .init_done(init_done),
    .store_fault(store_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference load extraction on a byte-shifted word.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] a);
    logic [31:0] sh;
    sh = w >> (8 * a);
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b001:  return a[0] ? 32'h0 : {{16{sh[15]}}, sh[15:0]};
      3'b101:  return a[0] ? 32'h0 : {16'h0, sh[15:0]};
      3'b010:  return (a == 2'b00) ? w : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  // Drive one RUN cycle, push the expected read result, update the model, advance one edge.
  task automatic drive_cycle(input vec_t v);
    logic [11:0] idx;
    logic [1:0]  off;
    logic [31:0] w;
    data_mem_rw = v.rw; data_mem_addr_o = v.addr; data_mem_control = v.f3;
    data_mem_data_wr_data = v.wd; load_we = v.lwe; load_addr = v.la; load_data = v.ld;
    idx = v.addr[13:2];
    off = v.addr[1:0];
    if (v.rw) sb_q.push_back(32'h0);
    else sb_q.push_back(ref_load(mdl[idx], v.f3, off));
    if (v.lwe) mdl[v.la] = v.ld;
    if (v.rw) begin
      w = mdl[idx];
      case (v.f3)
        3'b000: begin w[8*off +: 8] = v.wd[7:0]; mdl[idx] = w; end
        3'b001: if (off[0]) mdl_fault = 1'b1; else begin w[16*off[1] +: 16] = v.wd[15:0]; mdl[idx] = w; end
        3'b010: if (off != 2'b00) mdl_fault = 1'b1; else mdl[idx] = v.wd;
        default: mdl_fault = 1'b1;
      endcase
    end
    @(posedge clk); #1;
    data_mem_rw = 1'b0; load_we = 1'b0;
  endtask

  task automatic test_reset(input string tag);
    int n;
    logic init_bad;
    logic [31:0] exp;
    reset = 1'b1; data_mem_rw = 1'b0; load_we = 1'b0; data_mem_addr_o = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (instruction_i !== 32'h0000_0013) begin n_bad++; $display("FAIL %s instr: got %h expected 00000013", tag, instruction_i); end
    n_vec++; if (instruction_valid !== 1'b0) begin n_bad++; $display("FAIL %s valid: got %b expected 0", tag, instruction_valid); end
    n_vec++; if (data_mem_data_rd_data !== 32'h0) begin n_bad++; $display("FAIL %s rd_data: got %h expected 0", tag, data_mem_data_rd_data); end
    n_vec++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL %s init_done: got %b expected 0", tag, init_done); end
    n_vec++; if (store_fault !== 1'b0) begin n_bad++; $display("FAIL %s store_fault: got %b expected 0", tag, store_fault); end
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    init_bad = 1'b0;
    while (init_done !== 1'b1 && n < 5000) begin
      @(posedge clk); #1;
      n++;
      if (instruction_valid !== 1'b0 || data_mem_data_rd_data !== 32'h0) init_bad = 1'b1;
    end
    n_vec++; if (n !== 4096) begin n_bad++; $display("FAIL %s init_cycles: got %0d expected 4096", tag, n); end
    n_vec++; if (init_bad !== 1'b0) begin n_bad++; $display("FAIL %s init_quiet: got %b expected 0", tag, init_bad); end
    for (int i = 0; i < 4096; i++) mdl[i] = 32'h0;
    mdl_fault = 1'b0;
    sb_q.delete();
    drive_cycle('{1'b0, 32'h14, 3'b010, 32'h0, 1'b0, 12'h0, 32'h0, 32'h0});
    exp = sb_q.pop_front();
    n_vec++; if (data_mem_data_rd_data !== exp || data_mem_data_rd_data !== 32'h0) begin n_bad++; $display("FAIL %s lw_word5: got %h expected %h", tag, data_mem_data_rd_data, exp); end
    n_vec++; if (instruction_valid !== 1'b1) begin n_bad++; $display("FAIL %s valid_run: got %b expected 1", tag, instruction_valid); end
  endtask

  task automatic test_byte_half();
    vec_t v [11];
    logic [31:0] exp;
    v = '{
      '{1'b0, 32'h0, 3'b010, 32'h0, 1'b1, 12'd0, 32'h8081_F2F3, 32'h0},
      '{1'b0, 32'h1, 3'b000, 32'h0, 1'b0, 12'd0, 32'h0, 32'hFFFF_FFF2},
      '{1'b0, 32'h3, 3'b100, 32'h0, 1'b0, 12'd0, 32'h0, 32'h0000_0080},
      '{1'b0, 32'h2, 3'b001, 32'h0, 1'b0, 12'd0, 32'h0, 32'hFFFF_8081},
      '{1'b0, 32'h0, 3'b101, 32'h0, 1'b0, 12'd0, 32'h0, 32'h0000_F2F3},
      '{1'b0, 32'h0, 3'b010, 32'h0, 1'b0, 12'd0, 32'h0, 32'h8081_F2F3},
      '{1'b0, 32'h1, 3'b001, 32'h0, 1'b0, 12'd0, 32'h0, 32'h0},
      '{1'b0, 32'h2, 3'b010, 32'h0, 1'b0, 12'd0, 32'h0, 32'h0},
      '{1'b0, 32'h0, 3'b110, 32'h0, 1'b0, 12'd0, 32'h0, 32'h0},
      '{1'b0, 32'h2, 3'b101, 32'h0, 1'b0, 12'd0, 32'h0, 32'h0000_8081},
      '{1'b0, 32'h0, 3'b000, 32'h0, 1'b0, 12'd0, 32'h0, 32'hFFFF_FFF3}
    };
    for (int i = 0; i < 11; i++) begin
      drive_cycle(v[i]);
      exp = sb_q.pop_front();
      n_vec++; if (data_mem_data_rd_data !== exp || data_mem_data_rd_data !== v[i].want) begin n_bad++; $display("FAIL byte_half[%0d]: got %h expected %h", i, data_mem_data_rd_data, v[i].want); end
    end
  endtask

  task automatic test_store_byte();
    vec_t v [4];
    logic [31:0] exp;
    v = '{
      '{1'b1, 32'h40, 3'b010, 32'h1234_5678, 1'b0, 12'd0, 32'h0, 32'h0},
      '{1'b1, 32'h41, 3'b000, 32'h5555_55AA, 1'b0, 12'd0, 32'h0, 32'h0},
      '{1'b0, 32'h40, 3'b010, 32'h0, 1'b0, 12'd0, 32'h0, 32'h1234_AA78},
      '{1'b0, 32'h41, 3'b100, 32'h0, 1'b0, 12'd0, 32'h0, 32'h0000_00AA}
    };
    for (int i = 0; i < 4; i++) begin
      drive_cycle(v[i]);
      exp = sb_q.pop_front();
      n_vec++; if (data_mem_data_rd_data !== exp || data_mem_data_rd_data !== v[i].want) begin n_bad++; $display("FAIL store_byte[%0d]: got %h expected %h", i, data_mem_data_rd_data, v[i].want); end
    end
    n_vec++; if (store_fault !== 1'b0) begin n_bad++; $display("FAIL store_byte fault: got %b expected 0", store_fault); end
  endtask

  task automatic test_store_fault();
    vec_t v [7];
    logic [31:0] exp;
    v = '{
      '{1'b1, 32'h43, 3'b001, 32'h0000_BEEF, 1'b0, 12'd0, 32'h0, 32'h0},
      '{1'b0, 32'h40, 3'b010, 32'h0, 1'b0, 12'd0, 32'h0, 32'h1234_AA78},
      '{1'b1, 32'h42, 3'b010, 32'hFFFF_FFFF, 1'b0, 12'd0, 32'h0, 32'h0},
      '{1'b1, 32'h40, 3'b011, 32'hFFFF_FFFF, 1'b0, 12'd0, 32'h0, 32'h0},
      '{1'b0, 32'h40, 3'b010, 32'h0, 1'b0, 12'd0, 32'h0, 32'h1234_AA78},
      '{1'b1, 32'h40, 3'b010, 32'hCAFE_F00D, 1'b0, 12'd0, 32'h0, 32'h0},
      '{1'b0, 32'h40, 3'b010, 32'h0, 1'b0, 12'd0, 32'h0, 32'hCAFE_F00D}
    };
    for (int i = 0; i < 7; i++) begin
      drive_cycle(v[i]);
      exp = sb_q.pop_front();
      n_vec++; if (data_mem_data_rd_data !== exp || data_mem_data_rd_data !== v[i].want) begin n_bad++; $display("FAIL store_fault_rd[%0d]: got %h expected %h", i, data_mem_data_rd_data, v[i].want); end
      n_vec++; if (store_fault !== 1'b1 || store_fault !== mdl_fault) begin n_bad++; $display("FAIL store_fault_flag[%0d]: got %b expected 1", i, store_fault); end
    end
  endtask

  task automatic test_loader_store();
    vec_t v [6];
    logic [31:0] exp;
    v = '{
      '{1'b1, 32'h40, 3'b000, 32'h0, 1'b1, 12'd16, 32'hFFFF_FFFF, 32'h0},
      '{1'b0, 32'h40, 3'b010, 32'h0, 1'b0, 12'd0, 32'h0, 32'hFFFF_FF00},
      '{1'b1, 32'h54, 3'b010, 32'h1122_3344, 1'b1, 12'd20, 32'hA5A5_A5A5, 32'h0},
      '{1'b0, 32'h50, 3'b010, 32'h0, 1'b0, 12'd0, 32'h0, 32'hA5A5_A5A5},
      '{1'b0, 32'h54, 3'b010, 32'h0, 1'b0, 12'd0, 32'h0, 32'h1122_3344},
      '{1'b0, 32'h4040, 3'b010, 32'h0, 1'b0, 12'd0, 32'h0, 32'hFFFF_FF00}
    };
    for (int i = 0; i < 6; i++) begin
      drive_cycle(v[i]);
      exp = sb_q.pop_front();
      n_vec++; if (data_mem_data_rd_data !== exp || data_mem_data_rd_data !== v[i].want) begin n_bad++; $display("FAIL loader_store[%0d]: got %h expected %h", i, data_mem_data_rd_data, v[i].want); end
    end
  endtask

  task automatic test_fetch_reset();
    vec_t v [4];
    logic [31:0] ins_a [4];
    logic [31:0] ins_w [4];
    logic [31:0] exp;
    v = '{
      '{1'b0, 32'h0, 3'b010, 32'h0, 1'b1, 12'd17, 32'h0010_0093, 32'h8081_F2F3},
      '{1'b0, 32'h0, 3'b010, 32'h0, 1'b0, 12'd0, 32'h0, 32'h8081_F2F3},
      '{1'b1, 32'h40, 3'b010, 32'hDEAD_BEEF, 1'b0, 12'd0, 32'h0, 32'h0},
      '{1'b0, 32'h44, 3'b010, 32'h0, 1'b0, 12'd0, 32'h0, 32'h0010_0093}
    };
    ins_a = '{32'h40, 32'h44, 32'h42, 32'h4040};
    ins_w = '{32'hFFFF_FF00, 32'h0010_0093, 32'hFFFF_FF00, 32'hDEAD_BEEF};
    for (int i = 0; i < 4; i++) begin
      ins_address = ins_a[i];
      drive_cycle(v[i]);
      exp = sb_q.pop_front();
      n_vec++; if (data_mem_data_rd_data !== exp || data_mem_data_rd_data !== v[i].want) begin n_bad++; $display("FAIL fetch_rd[%0d]: got %h expected %h", i, data_mem_data_rd_data, v[i].want); end
      n_vec++; if (instruction_i !== ins_w[i] || instruction_valid !== 1'b1) begin n_bad++; $display("FAIL fetch[%0d]: got %h/%b expected %h/1", i, instruction_i, instruction_valid, ins_w[i]); end
    end
    reset = 1'b1;
    #1;
    n_vec++; if (instruction_valid !== 1'b0) begin n_bad++; $display("FAIL midreset valid: got %b expected 0", instruction_valid); end
    n_vec++; if (instruction_i !== 32'h0000_0013) begin n_bad++; $display("FAIL midreset instr: got %h expected 00000013", instruction_i); end
    n_vec++; if (store_fault !== 1'b0 || init_done !== 1'b0) begin n_bad++; $display("FAIL midreset flags: got %b%b expected 00", store_fault, init_done); end
    test_reset("reinit");
    drive_cycle('{1'b0, 32'h40, 3'b010, 32'h0, 1'b0, 12'd0, 32'h0, 32'h0});
    exp = sb_q.pop_front();
    n_vec++; if (data_mem_data_rd_data !== exp || data_mem_data_rd_data !== 32'h0) begin n_bad++; $display("FAIL reinit_cleared: got %h expected 00000000", data_mem_data_rd_data); end
  endtask

  initial begin
    test_reset("powerup");
    test_byte_half();
    test_store_byte();
    test_store_fault();
    test_loader_store();
    test_fetch_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
